// File: rtl/id_pkg.sv
// Shared opcode constants and decode flags for the instruction-decode stage.
package id_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;

   typedef struct packed {
      logic branch;
      logic jump;
      logic reg_write;
      logic mem_read;
      logic dest_is_rd;
   } dec_flags_t;

   function automatic dec_flags_t decode_op(input logic [5:0] op);
      dec_flags_t f;
      f = '0;
      case (op)
         OP_RTYPE: begin
            f.reg_write  = 1'b1;
            f.dest_is_rd = 1'b1;
         end
         OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI: f.reg_write = 1'b1;
         OP_LW: begin
            f.reg_write = 1'b1;
            f.mem_read  = 1'b1;
         end
         OP_BEQ, OP_BNE: f.branch = 1'b1;
         OP_J:           f.jump   = 1'b1;
         default: ;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/id_stage_hazard_if.sv
// ID/EX pipeline register bundle: decode drives it (master), EX consumes it (slave).
interface id_stage_hazard_if #(
   parameter int unsigned DATA_W = 32
);
   logic              idex_valid;
   logic [5:0]        idex_opcode;
   logic [5:0]        idex_funct;
   logic [DATA_W-1:0] idex_rs_data;
   logic [DATA_W-1:0] idex_rt_data;
   logic [DATA_W-1:0] idex_imm;
   logic [4:0]        idex_rs;
   logic [4:0]        idex_rt;
   logic [4:0]        idex_dest;
   logic              idex_reg_write;
   logic              idex_mem_read;

   modport master (
      output idex_valid, idex_opcode, idex_funct, idex_rs_data, idex_rt_data,
             idex_imm, idex_rs, idex_rt, idex_dest, idex_reg_write, idex_mem_read
   );

   modport slave (
      input  idex_valid, idex_opcode, idex_funct, idex_rs_data, idex_rt_data,
             idex_imm, idex_rs, idex_rt, idex_dest, idex_reg_write, idex_mem_read
   );
endinterface

// File: rtl/id_stage_hazard_regfile.sv
// 32-entry 2R/1W register file; r0 is hard zero, optional write-before-read bypass.
module id_regfile #(
   parameter int unsigned DATA_W    = 32,
   parameter bit          WB_BYPASS = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [4:0]        waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [4:0]        raddr_a,
   input  logic [4:0]        raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b
);

   logic [DATA_W-1:0] regs_q [32];
   logic [DATA_W-1:0] regs_d [32];
   logic              wr_live;

   assign wr_live = we && (waddr != '0);

   always_comb begin
      regs_d = regs_q;
      if (wr_live) regs_d[waddr] = wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) regs_q <= '{default: '0};
      else        regs_q <= regs_d;
   end

   always_comb begin
      rdata_a = regs_q[raddr_a];
      rdata_b = regs_q[raddr_b];
      if (WB_BYPASS && wr_live && raddr_a == waddr) rdata_a = wdata;
      if (WB_BYPASS && wr_live && raddr_b == waddr) rdata_b = wdata;
      if (raddr_a == '0) rdata_a = '0;
      if (raddr_b == '0) rdata_b = '0;
   end

endmodule

// File: rtl/id_stage_hazard.sv
// Decode stage with ID/EX register, load-use/branch hazard stall, EX/MEM branch
// forwarding and branch/jump resolution.
module id_stage_hazard
   import id_pkg::*;
#(
   parameter int unsigned DATA_W     = 32,
   parameter bit          WB_BYPASS  = 1'b1,
   parameter bit          BRANCH_FWD = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              ifid_valid,
   input  logic [31:0]       ifid_instr,
   input  logic [DATA_W-1:0] ifid_pc_plus4,
   input  logic              wb_we,
   input  logic [4:0]        wb_reg,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              exmem_we,
   input  logic              exmem_mem_read,
   input  logic [4:0]        exmem_reg,
   input  logic [DATA_W-1:0] exmem_data,
   output logic              stall,
   output logic              if_flush,
   output logic              pc_src,
   output logic [DATA_W-1:0] branch_target,
   output logic              jump,
   output logic [DATA_W-1:0] jump_target,
   id_stage_hazard_if.master idex
);

   logic [5:0]        opcode;
   logic [4:0]        rs_a, rt_a, rd_a;
   logic [DATA_W-1:0] imm_ext, rf_rs, rf_rt, op_a, op_b;
   dec_flags_t        dec;
   logic              ex_hit_rs, ex_hit_rt, idex_hit, load_use, br_haz, taken, stall_c;

   logic              valid_q, valid_d, reg_write_q, reg_write_d, mem_read_q, mem_read_d;
   logic [5:0]        opcode_q, opcode_d, funct_q, funct_d;
   logic [4:0]        rs_q, rs_d, rt_q, rt_d, dest_q, dest_d;
   logic [DATA_W-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;

   assign opcode  = ifid_instr[31:26];
   assign rs_a    = ifid_instr[25:21];
   assign rt_a    = ifid_instr[20:16];
   assign rd_a    = ifid_instr[15:11];
   assign imm_ext = {{(DATA_W-16){ifid_instr[15]}}, ifid_instr[15:0]};

   id_regfile #(.DATA_W(DATA_W), .WB_BYPASS(WB_BYPASS)) u_regfile (
      .clk     (clk),
      .rst_n   (reset_n),
      .we      (wb_we),
      .waddr   (wb_reg),
      .wdata   (wb_data),
      .raddr_a (rs_a),
      .raddr_b (rt_a),
      .rdata_a (rf_rs),
      .rdata_b (rf_rt)
   );

   // Without forwarding, any EX/MEM producer of a branch operand must drain first.
   always_comb begin
      dec       = ifid_valid ? decode_op(opcode) : '0;
      ex_hit_rs = exmem_we && (exmem_reg != '0) && (exmem_reg == rs_a);
      ex_hit_rt = exmem_we && (exmem_reg != '0) && (exmem_reg == rt_a);
      idex_hit  = valid_q && (dest_q != '0) && ((dest_q == rs_a) || (dest_q == rt_a));
      load_use  = idex_hit && mem_read_q;
      br_haz    = dec.branch && ((idex_hit && reg_write_q) ||
                  ((exmem_mem_read || !BRANCH_FWD) && (ex_hit_rs || ex_hit_rt)));
      stall_c   = ifid_valid && (load_use || br_haz);
      op_a      = (BRANCH_FWD && ex_hit_rs) ? exmem_data : rf_rs;
      op_b      = (BRANCH_FWD && ex_hit_rt) ? exmem_data : rf_rt;
      taken     = dec.branch && ((opcode == OP_BEQ) ? (op_a == op_b) : (op_a != op_b));
   end

   assign stall         = stall_c;
   assign pc_src        = taken && !stall_c;
   assign jump          = dec.jump && !stall_c;
   assign if_flush      = pc_src || jump;
   assign branch_target = ifid_pc_plus4 + (imm_ext << 2);
   assign jump_target   = {ifid_pc_plus4[DATA_W-1:28], ifid_instr[25:0], 2'b00};

   always_comb begin
      valid_d     = ifid_valid && !stall_c;
      reg_write_d = dec.reg_write && !stall_c;
      mem_read_d  = dec.mem_read && !stall_c;
      opcode_d    = opcode;
      funct_d     = ifid_instr[5:0];
      rs_d        = rs_a;
      rt_d        = rt_a;
      dest_d      = dec.dest_is_rd ? rd_a : rt_a;
      rs_data_d   = rf_rs;
      rt_data_d   = rf_rt;
      imm_d       = imm_ext;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q     <= 1'b0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         opcode_q    <= '0;
         funct_q     <= '0;
         rs_q        <= '0;
         rt_q        <= '0;
         dest_q      <= '0;
         rs_data_q   <= '0;
         rt_data_q   <= '0;
         imm_q       <= '0;
      end else begin
         valid_q     <= valid_d;
         reg_write_q <= reg_write_d;
         mem_read_q  <= mem_read_d;
         opcode_q    <= opcode_d;
         funct_q     <= funct_d;
         rs_q        <= rs_d;
         rt_q        <= rt_d;
         dest_q      <= dest_d;
         rs_data_q   <= rs_data_d;
         rt_data_q   <= rt_data_d;
         imm_q       <= imm_d;
      end
   end

   assign idex.idex_valid     = valid_q;
   assign idex.idex_reg_write = reg_write_q;
   assign idex.idex_mem_read  = mem_read_q;
   assign idex.idex_opcode    = opcode_q;
   assign idex.idex_funct     = funct_q;
   assign idex.idex_rs        = rs_q;
   assign idex.idex_rt        = rt_q;
   assign idex.idex_dest      = dest_q;
   assign idex.idex_rs_data   = rs_data_q;
   assign idex.idex_rt_data   = rt_data_q;
   assign idex.idex_imm       = imm_q;

endmodule

// File: doc/id_stage_hazard.md
Name: id_stage_hazard

Overview:
- Parametrised successor of the single-cycle-style instruction decode stage: register file, sign extension, branch/jump resolution in ID, plus a registered ID/EX pipeline register.
- Adds what the current decode lacks: ID/EX staging with a valid bit, load-use and branch-operand hazard detection with a stall output, EX/MEM-to-ID forwarding into the branch comparator, and write-before-read register-file bypass.
- Sits between the IF/ID register and the EX stage. Drives PC select, IF/ID hold and IF/ID flush.

Parameters:
DATA_W, 32, datapath/address width; must be >= 32. Instructions are always 32 bits.
WB_BYPASS, 1, 1 = register-file read returns the same-cycle WB write data on an address match.
BRANCH_FWD, 1, 1 = branch comparator takes EX/MEM forwarding; 0 = stall until the producer has written back.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset_n  in  1  asynchronous, active-low reset
ifid_valid  in  1  IF/ID holds a real instruction
ifid_instr  in  32  instruction
ifid_pc_plus4  in  DATA_W  PC+4 of the instruction
wb_we  in  1  writeback enable
wb_reg  in  5  writeback register
wb_data  in  DATA_W  writeback data
exmem_we  in  1  EX/MEM instruction writes a register
exmem_mem_read  in  1  EX/MEM instruction is a load
exmem_reg  in  5  EX/MEM destination register
exmem_data  in  DATA_W  EX/MEM ALU result
stall  out  1  hold PC and IF/ID
if_flush  out  1  squash IF/ID on the next edge
pc_src  out  1  take branch_target
branch_target  out  DATA_W  ifid_pc_plus4 + (sext(imm) << 2), modulo 2^DATA_W
jump  out  1  take jump_target
jump_target  out  DATA_W  {ifid_pc_plus4[DATA_W-1:28], instr[25:0], 2'b00}
idex_valid  out  1  ID/EX holds a real instruction
idex_opcode  out  6  registered opcode
idex_funct  out  6  registered funct
idex_rs_data  out  DATA_W  registered rs read value
idex_rt_data  out  DATA_W  registered rt read value
idex_imm  out  DATA_W  registered sign-extended immediate
idex_rs  out  5  registered rs
idex_rt  out  5  registered rt
idex_dest  out  5  registered destination: rd for R-type, rt otherwise
idex_reg_write  out  1  registered register-write flag
idex_mem_read  out  1  registered load flag

Behaviour:
- Register file: 32 x DATA_W registers. r0 reads 0 and writes to it are ignored. Write on clk when wb_we=1. Reset clears all registers to 0.
- Read path: with WB_BYPASS=1, a read whose address equals wb_reg (and wb_we=1, wb_reg!=0) returns wb_data. With WB_BYPASS=0, the read returns the old register value.
- Decode, gated by ifid_valid:
  - branch: opcode BEQ=0x04 or BNE=0x05
  - jump: opcode J=0x02
  - reg_write: opcode in {0x00, 0x08, 0x09, 0x0C, 0x0D, 0x23}
  - mem_read: opcode 0x23
- Load-use hazard: idex_valid & idex_mem_read & idex_dest!=0 & (idex_dest==rs | idex_dest==rt).
- Branch hazard, only when the ID instruction is a branch:
  - (idex_valid & idex_reg_write & idex_dest!=0 & idex_dest matches rs or rt), or
  - (exmem_mem_read & exmem_we & exmem_reg!=0 & exmem_reg matches rs or rt), or
  - with BRANCH_FWD=0, any exmem_we match on rs or rt.
- stall = ifid_valid & (load-use | branch hazard). stall is combinational, zero latency.
- While stall=1:
  - pc_src=0, jump=0, if_flush=0
  - ID/EX loads a bubble: idex_valid=0 and idex_reg_write=0, idex_mem_read=0
  - the other idex_* fields are don't-care
- Branch operands:
  - If BRANCH_FWD=1, exmem_we=1, exmem_reg!=0 and exmem_reg equals the operand register, the operand is exmem_data.
  - Otherwise the operand is the register-file read value (including the WB bypass).
- Branch resolution:
  - Taken when BEQ and operands are equal, or BNE and operands differ.
  - Taken and not stalled: pc_src=1, if_flush=1.
- Jump: ifid_valid, opcode J and not stalled gives jump=1, if_flush=1. Jump has no operand hazard.
- When not stalled, ID/EX captures the decoded fields and idex_valid=ifid_valid on every edge. A taken branch or jump still advances into ID/EX, valid.
- ifid_valid=0: stall=0, pc_src=0, jump=0, if_flush=0; ID/EX loads a bubble.
- branch_target and jump_target are always driven combinationally, whatever the opcode.
- Reset:
  - all idex_* outputs and the register file go to 0 immediately
  - stall, pc_src, jump, if_flush are 0 after reset provided ifid_valid=0
  - a reset mid-stall drops the stall, because idex_valid is cleared
- Simultaneous WB write and EX/MEM match on the same register: EX/MEM has priority in the branch comparator.

Decomposition:
- Package id_pkg holds the opcode constants (OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_LW) and a decode-flags struct (branch, jump, reg_write, mem_read, dest_is_rd).
- One sub-module, id_regfile: a parametrised 2-read/1-write register file with an async active-low clear and the WB_BYPASS option.
- Hazard logic, forwarding and the ID/EX register stay in id_stage_hazard.

Test Plan:
1. Write r5=0x1234 via WB, then instr add r6,r5,r5 valid -> next edge: idex_rs_data=0x1234, idex_rt_data=0x1234, idex_dest=6, idex_valid=1.
2. lw r2 in ID/EX, ID holds add r3,r2,r1 -> stall=1 for exactly one cycle with an idex_valid=0 bubble; the next cycle stall=0 and add enters ID/EX.
3. beq r1,r4 with exmem_we=1, exmem_reg=4, exmem_data equal to r1 -> pc_src=1, if_flush=1, branch_target=pc_plus4+(imm<<2); repeat with imm=0xFFFF to check the negative offset (target = pc_plus4 - 4).
4. bne r7,r0 with an ALU producer of r7 in ID/EX -> stall=1 one cycle; the next cycle resolves using EX/MEM forwarding; with BRANCH_FWD=0 the stall persists until writeback.
5. j 0x0000040 at pc_plus4=0x40000004 -> jump=1, if_flush=1, jump_target=0x40000100.
6. Assert reset_n low during a load-use stall -> all idex_* outputs 0 and stall=0 immediately; a write to r0 followed by a read of r0 returns 0.
